// File: rtl/key_expansion_multi.sv
// AES-128/192/256 key schedule generator: one schedule word per clock into a
// round-key store, with a combinational round-key read port once complete.
`timescale 1ns/1ps
module key_expansion_multi #(
  parameter int MAX_NK      = 8,
  parameter bit RD_ZERO_OOR = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  input  logic [3:0]   round,
  output logic [127:0] round_key_out,
  output logic         ready,
  output logic         busy,
  output logic         cfg_err
);

  localparam int DEPTH = 4 * (MAX_NK + 7);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t      state, next_state;
  logic [31:0] store [0:DEPTH-1];
  logic [3:0]  nk_q, nr_q;
  logic [5:0]  i_q;
  logic [2:0]  phase_q;
  logic [7:0]  rcon_q;

  logic [3:0]  req_nk, req_nr;
  logic        legal;
  logic        last_word;
  logic [5:0]  prev_idx, back_idx;
  logic [31:0] prev_word, back_word, sub_in, sub_out, temp, new_word;
  logic [3:0]  rd_round;
  logic [5:0]  rd_base;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, r;
    p = gf_mul(a, a);
    r = p;
    for (int k = 0; k < 6; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    case (key_len)
      2'b01:   req_nk = 4'd6;
      2'b10:   req_nk = 4'd8;
      default: req_nk = 4'd4;
    endcase
    req_nr    = req_nk + 4'd6;
    legal     = (key_len != 2'b11) && (int'(req_nk) <= MAX_NK);
    last_word = (i_q == {nr_q, 2'b11});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (start)
      next_state = legal ? EXPAND : IDLE;
    else if (state == EXPAND && last_word)
      next_state = DONE;
    ready = (state == DONE);
    busy  = (state == EXPAND);
  end

  // phase_q tracks i mod Nk so no divider is needed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      nk_q    <= 4'd4;
      nr_q    <= 4'd10;
      i_q     <= 6'd0;
      phase_q <= 3'd0;
      rcon_q  <= 8'h01;
    end else if (start) begin
      if (legal) begin
        cfg_err <= 1'b0;
        nk_q    <= req_nk;
        nr_q    <= req_nr;
        i_q     <= {2'b00, req_nk};
        phase_q <= 3'd0;
        rcon_q  <= 8'h01;
      end else begin
        cfg_err <= 1'b1;
      end
    end else if (state == EXPAND) begin
      i_q     <= i_q + 6'd1;
      phase_q <= ({1'b0, phase_q} == nk_q - 4'd1) ? 3'd0 : phase_q + 3'd1;
      if (phase_q == 3'd0)
        rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
  end

  always_comb begin
    prev_idx  = i_q - 6'd1;
    back_idx  = i_q - {2'b00, nk_q};
    prev_word = store[prev_idx];
    back_word = store[back_idx];
    sub_in    = (phase_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                 sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    if (phase_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h000000};
    else if (nk_q == 4'd8 && phase_q == 3'd4)
      temp = sub_out;
    else
      temp = prev_word;
    new_word = back_word ^ temp;
  end

  // Rejected starts leave the store untouched
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (start) begin
        if (legal) begin
          for (int k = 0; k < MAX_NK; k++)
            if (k < int'(req_nk))
              store[k] <= key_in[255 - 32*k -: 32];
        end
      end else if (state == EXPAND) begin
        store[i_q] <= new_word;
      end
    end
  end

  always_comb begin
    rd_round      = (round > nr_q) ? nr_q : round;
    rd_base       = {rd_round, 2'b00};
    round_key_out = 128'd0;
    if (ready && !(RD_ZERO_OOR && (round > nr_q)))
      round_key_out = {store[rd_base], store[rd_base | 6'd1],
                       store[rd_base | 6'd2], store[rd_base | 6'd3]};
  end

endmodule

// File: tb/tb_key_expansion_multi.sv
// Scoreboard bench for key_expansion_multi using FIPS-197 key schedule vectors.
`timescale 1ns/1ps
module tb_key_expansion_multi;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   round;
  logic [127:0] round_key_out;
  logic         ready;
  logic         busy;
  logic         cfg_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    string        name;
  } exp_t;

  exp_t sb[$];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                   128'hdeadbeef0123456789abcdeffeedface};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                   64'hcafebabe55aa33cc};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_expansion_multi dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .key_len       (key_len),
    .key_in        (key_in),
    .round         (round),
    .round_key_out (round_key_out),
    .ready         (ready),
    .busy          (busy),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task push_exp(input logic [3:0] rnd, input logic [127:0] key, input string name);
    exp_t e;
    e.rnd  = rnd;
    e.key  = key;
    e.name = name;
    sb.push_back(e);
  endtask

  // Ends 1 ns after the load edge; the inputs are then scrambled
  task do_start(input logic [1:0] len, input logic [255:0] key);
    @(negedge clk);
    key_len = len;
    key_in  = key;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    key_in  = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
    key_len = 2'($urandom_range(0, 3));
  endtask

  task wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task drain_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      round = e.rnd;
      #1;
      total++;
      if (round_key_out !== e.key) begin
        bad++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, round_key_out, e.key);
      end
    end
  endtask

  task test_reset();
    rst_n   = 1'b0;
    start   = 1'b1;
    key_len = 2'b00;
    key_in  = K128;
    round   = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ready, busy, cfg_err} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {ready, busy, cfg_err});
    end
    total++;
    if (round_key_out !== 128'd0) begin
      bad++;
      $display("[TB] FAIL reset_read: got %h expected 0", round_key_out);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task test_expand(input logic [1:0] len, input logic [255:0] key,
                   input int exp_cycles, input string name);
    int cycles;
    do_start(len, key);
    total++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_busy: got busy=%b ready=%b expected busy=1 ready=0",
               name, busy, ready);
    end
    wait_ready(cycles);
    total++;
    if (cycles != exp_cycles) begin
      bad++;
      $display("[TB] FAIL %s_latency: got %0d expected %0d", name, cycles, exp_cycles);
    end
    drain_sb();
    total++;
    if (busy !== 1'b0 || cfg_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_done_flags: got busy=%b cfg_err=%b expected 0 0",
               name, busy, cfg_err);
    end
  endtask

  task test_aes128();
    push_exp(4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "aes128_r0");
    push_exp(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "aes128_r1");
    push_exp(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_r10");
    push_exp(4'd11, 128'd0,                                "aes128_r11_oor");
    test_expand(2'b00, K128, 40, "aes128");
  endtask

  task test_aes192();
    push_exp(4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5, "aes192_r0");
    push_exp(4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, "aes192_r1");
    push_exp(4'd12, 128'he98ba06f448c773c8ecc720401002202, "aes192_r12");
    push_exp(4'd13, 128'd0,                                "aes192_r13_oor");
    test_expand(2'b01, K192, 46, "aes192");
  endtask

  task test_aes256();
    push_exp(4'd0,  128'h603deb1015ca71be2b73aef0857d7781, "aes256_r0");
    push_exp(4'd1,  128'h1f352c073b6108d72d9810a30914dff4, "aes256_r1");
    push_exp(4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_r14");
    push_exp(4'd15, 128'd0,                                "aes256_r15_oor");
    test_expand(2'b10, K256, 52, "aes256");
  endtask

  task test_restart();
    int seen;
    seen = 0;
    do_start(2'b10, K256);
    repeat (19) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL restart_early_ready: got %0d ready cycles expected 0", seen);
    end
    push_exp(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "restart_r1");
    push_exp(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "restart_r10");
    test_expand(2'b00, K128, 40, "restart");
  endtask

  task test_bad_len();
    round = 4'd0;
    do_start(2'b11, K256);
    total++;
    if ({cfg_err, ready, busy} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL bad_len_flags: got cfg_err/ready/busy=%b expected 100",
               {cfg_err, ready, busy});
    end
    total++;
    if (round_key_out !== 128'd0) begin
      bad++;
      $display("[TB] FAIL bad_len_read: got %h expected 0", round_key_out);
    end
    push_exp(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "after_bad_r10");
    test_expand(2'b00, K128, 40, "after_bad");
  endtask

  task test_reset_mid();
    int seen;
    seen = 0;
    do_start(2'b00, K128);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({ready, busy, cfg_err} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_mid_flags: got %b expected 000", {ready, busy, cfg_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    round = 4'd0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (ready || busy || round_key_out != 128'd0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL reset_mid_idle: got %0d active cycles expected 0", seen);
    end
  endtask

  initial begin
    $display("[TB] key_expansion_multi bench start");
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_restart();
    test_bad_len();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_expansion_multi.md
Name: key_expansion_multi

Overview:
Next-generation AES key schedule generator supporting AES-128/192/256, selected per operation at run time. On `start` it latches the cipher key and computes one 32-bit schedule word per clock into an internal round-key store. Once `ready` is high, the store serves any round key combinationally through the `round` read port. It replaces the fixed 128-bit key expansion ahead of the AES-CTR round datapath.

Parameters:
MAX_NK, 8, largest supported key length in 32-bit words. Legal values are 4, 6, 8; storage is 4*(MAX_NK+7) words.
RD_ZERO_OOR, 1, out-of-range read policy. 1: `round` > Nr returns 0. 0: returns the round-Nr key.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle pulse; sample `key_len`/`key_in` and begin expansion
key_len  input  2  00=AES-128 (Nk4/Nr10), 01=AES-192 (Nk6/Nr12), 10=AES-256 (Nk8/Nr14), 11=illegal
key_in  input  256  cipher key, MSB-aligned: key word 0 = [255:224]; unused low bits ignored
round  input  4  round-key index to read
round_key_out  output  128  words w[4r]..w[4r+3], w[4r] in [127:96]; combinational from store
ready  output  1  schedule complete and valid for the latched key_len
busy  output  1  expansion in progress
cfg_err  output  1  last start request was rejected

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM to IDLE; ready=0, busy=0, cfg_err=0.
  - Latched key_len cleared to 00 (Nr=10).
  - Store contents undefined.
  - round_key_out reads 0 whenever ready=0.
- FSM states: IDLE, EXPAND, DONE.
- start is accepted in any state; a start during EXPAND aborts the current expansion and restarts.
- Start rejection: key_len=11, or Nk > MAX_NK.
  - cfg_err <= 1, ready <= 0, busy <= 0, state <= IDLE.
  - Store is not modified.
- Accepted start (LOAD edge):
  - Latch Nk and Nr; write key words w[0]..w[Nk-1] in parallel.
  - i <= Nk, rcon <= 8'h01, word-phase counter <= 0.
  - ready <= 0, busy <= 1, cfg_err <= 0, state <= EXPAND.
- EXPAND, each cycle writes w[i] = w[i-Nk] ^ temp, where temp is selected as follows:
  - i mod Nk == 0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then rcon <= xtime(rcon), with 8'h80 -> 8'h1b.
  - Nk==8 and i mod 8 == 4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
- Mod/div: i mod Nk comes from a wrapping phase counter 0..Nk-1. No divider; a single 4-byte S-box bank is shared.
- End of EXPAND: after writing w[4*Nr+3] (word 43/51/59), state <= DONE, ready <= 1, busy <= 0.
- Latency: ready is high exactly 40/46/52 clocks after the accepted start edge for AES-128/192/256.
- DONE: holds until the next start or reset.
- Read port:
  - ready=1 and round <= Nr: round_key_out = store words 4r..4r+3.
  - round > Nr: governed by RD_ZERO_OOR.
  - Read has no side effects and has zero-cycle latency from `round`.
- Reset mid-EXPAND: immediate return to IDLE, ready=0; a new start is required.
- start coincident with rst_n=0: reset wins.
- key_in and key_len may change freely after the start cycle without affecting the result.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c: ready rises 40 cycles after start.
  - round 0 = 2b7e1516..09cf4f3c; round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; round 11 reads 0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: ready after 46 cycles.
  - round 1 = 62f8ead2522c6b7bfe0c91f72402f5a5; round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: ready after 52 cycles.
  - round 1 = 1f352c073b6108d72d9810a30914dff4; round 14 = fe4890d1e6188d0b046df344706c631e.
- Restart: start AES-256, then re-start with the AES-128 key 20 cycles later.
  - ready stays 0 until 40 cycles after the second start.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- key_len=11 start while in DONE: cfg_err=1, ready=0, busy=0, round_key_out=0.
  - A following legal start clears cfg_err.
- rst_n=0 for one cycle mid-EXPAND: ready, busy and cfg_err are all 0 next cycle.
  - ready stays 0 for 100 cycles with no start.
